// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module  : wb_arb_pkg
// Brief   : Shared types and width helpers for the Wishbone memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Grant index width; a single requester still needs one bit of index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module  : rr_priority_picker
// Brief   : Combinational round-robin picker: first request after last_i wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan starting just after the previous winner, wrapping circularly.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
// ============================================================================
// Module  : wb_mem_arbiter
// Brief   : Round-robin Wishbone arbiter with stall watchdog for the DDR port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mem_ready_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_data_o,
  input  logic [DATA_WIDTH-1:0]             s_data_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int            IW       = idx_width(NUM_MASTERS);
  localparam int            CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] ABORT_AT = CW'(TIMEOUT_CYCLES - 2);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q,  last_d;
  logic [CW-1:0]          cnt_q,   cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic                   in_bus;
  logic                   cyc_g, stb_g, we_g;
  logic [ADDR_WIDTH-1:0]  addr_g;
  logic [DATA_WIDTH-1:0]  data_g;

  assign req = m_cyc_i & m_stb_i;

  rr_priority_picker #(
    .NUM_REQ (NUM_MASTERS)
  ) u_picker (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (pick),
    .valid_o  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  // Grant is one-hot, so the OR-style select yields the owner's signals.
  always_comb begin
    cyc_g  = 1'b0;
    stb_g  = 1'b0;
    we_g   = 1'b0;
    addr_g = '0;
    data_g = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        cyc_g  = m_cyc_i[i];
        stb_g  = m_stb_i[i];
        we_g   = m_we_i[i];
        addr_g = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_g = m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_bus   = (state_q == BUS);
  assign s_cyc_o  = in_bus & cyc_g;
  assign s_stb_o  = in_bus & cyc_g & stb_g;
  assign s_we_o   = in_bus & we_g;
  assign s_addr_o = in_bus ? addr_g : '0;
  assign s_data_o = in_bus ? data_g : '0;
  assign m_ack_o  = (in_bus && s_ack_i) ? grant_q : '0;
  assign m_err_o  = (state_q == ABORT) ? grant_q : '0;
  assign m_data_o = s_data_i;
  assign grant_o  = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_ready_i && pick_valid) begin
          grant_d = pick;
          last_d  = pick_idx;
          state_d = BUS;
        end
      end
      BUS: begin
        if (s_ack_i)      cnt_d = '0;
        else if (s_stb_o) cnt_d = cnt_q + 1'b1;
        // Owner releasing cyc takes precedence over the watchdog.
        if (!cyc_g) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s_stb_o && !s_ack_i && (cnt_q == ABORT_AT)) begin
          cnt_d   = '0;
          state_d = ABORT;
        end
      end
      ABORT: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
// ============================================================================
// Module  : tb_wb_mem_arbiter
// Brief   : Directed self-checking bench for wb_mem_arbiter (3 masters, 16-cycle watchdog).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_mem_arbiter;

  localparam int NM = 3;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int TO = 16;

  localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] PAT_3C = {32{8'h3C}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_ready_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*DW-1:0]  m_data_i;
  logic [DW-1:0]     m_data_o;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_data_o, s_data_i;
  logic              s_ack_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(
    .NUM_MASTERS    (NM),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_ready_i (mem_ready_i),
    .m_cyc_i     (m_cyc_i),
    .m_stb_i     (m_stb_i),
    .m_we_i      (m_we_i),
    .m_addr_i    (m_addr_i),
    .m_data_i    (m_data_i),
    .m_data_o    (m_data_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_data_o    (s_data_o),
    .s_data_i    (s_data_i),
    .s_ack_i     (s_ack_i),
    .grant_o     (grant_o)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic on);
    m_cyc_i[i] = on;
    m_stb_i[i] = on;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    settle();
    step();
    rst_n = 1'b1;
  endtask

  logic [NM-1:0] exp_g;
  int            g;

  initial begin
    rst_n       = 1'b0;
    mem_ready_i = 1'b0;
    m_cyc_i     = '0;
    m_stb_i     = '0;
    m_we_i      = '0;
    m_addr_i    = '0;
    m_data_i    = '0;
    s_data_i    = '0;
    s_ack_i     = 1'b0;
    m_addr_i[0*AW +: AW] = 32'h0000_1000;
    m_addr_i[1*AW +: AW] = 32'h0000_2000;
    m_addr_i[2*AW +: AW] = 32'h0000_3000;
    m_data_i[1*DW +: DW] = PAT_3C;

    // Reset state
    #12;
    check("rst_grant", 256'(grant_o), 256'(3'b000));
    check("rst_s_cyc", 256'(s_cyc_o), 256'(1'b0));
    check("rst_s_stb", 256'(s_stb_o), 256'(1'b0));
    check("rst_ack",   256'(m_ack_o), 256'(3'b000));
    check("rst_err",   256'(m_err_o), 256'(3'b000));
    check("rst_mdata", m_data_o, '0);
    step();
    rst_n       = 1'b1;
    mem_ready_i = 1'b1;

    // Single master read, ack after 5 cycles
    step();
    set_req(0, 1'b1);
    settle();
    check("t1_no_grant_yet", 256'(grant_o), 256'(3'b000));
    check("t1_idle_cyc",     256'(s_cyc_o), 256'(1'b0));
    step();
    settle();
    check("t1_grant",  256'(grant_o),  256'(3'b001));
    check("t1_s_cyc",  256'(s_cyc_o),  256'(1'b1));
    check("t1_s_stb",  256'(s_stb_o),  256'(1'b1));
    check("t1_s_we",   256'(s_we_o),   256'(1'b0));
    check("t1_s_addr", 256'(s_addr_o), 256'(32'h0000_1000));
    repeat (4) step();
    s_ack_i  = 1'b1;
    s_data_i = PAT_A5;
    settle();
    check("t1_ack",   256'(m_ack_o), 256'(3'b001));
    check("t1_mdata", m_data_o, PAT_A5);
    step();
    s_ack_i = 1'b0;
    set_req(0, 1'b0);
    settle();
    check("t1_ack_done", 256'(m_ack_o), 256'(3'b000));
    check("t1_cyc_drop", 256'(s_cyc_o), 256'(1'b0));
    step();
    settle();
    check("t1_idle", 256'(grant_o), 256'(3'b000));

    // Three masters, one beat each, ack and cyc drop in the same cycle
    pulse_reset();
    step();
    for (int i = 0; i < NM; i++) set_req(i, 1'b1);
    for (int t = 0; t < 4; t++) begin
      g     = t % NM;
      exp_g = 3'b001 << g;
      step();
      settle();
      check("t2_grant", 256'(grant_o), 256'(exp_g));
      s_ack_i = 1'b1;
      set_req(g, 1'b0);
      settle();
      check("t2_ack", 256'(m_ack_o), 256'(exp_g));
      step();
      s_ack_i = 1'b0;
      if (t < 3) set_req(g, 1'b1);
      else for (int i = 0; i < NM; i++) set_req(i, 1'b0);
      settle();
      check("t2_gap_grant", 256'(grant_o), 256'(3'b000));
      check("t2_gap_ack",   256'(m_ack_o), 256'(3'b000));
    end

    // Locked 4-beat write by m1 while m0/m2 wait
    pulse_reset();
    step();
    set_req(1, 1'b1);
    m_we_i[1] = 1'b1;
    step();
    settle();
    check("t3_grant",  256'(grant_o),  256'(3'b010));
    check("t3_s_we",   256'(s_we_o),   256'(1'b1));
    check("t3_s_addr", 256'(s_addr_o), 256'(32'h0000_2000));
    check("t3_s_data", s_data_o, PAT_3C);
    set_req(0, 1'b1);
    set_req(2, 1'b1);
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1;
      settle();
      check("t3_beat_ack", 256'(m_ack_o), 256'(3'b010));
      step();
      s_ack_i = 1'b0;
      settle();
      check("t3_hold", 256'(grant_o), 256'(3'b010));
      step();
    end
    set_req(1, 1'b0);
    m_we_i[1] = 1'b0;
    settle();
    check("t3_cyc_drop", 256'(s_cyc_o), 256'(1'b0));
    step();
    settle();
    check("t3_gap", 256'(grant_o), 256'(3'b000));
    step();
    settle();
    check("t3_next_m2", 256'(grant_o), 256'(3'b100));

    // mem_ready_i low blocks grants; spurious ack ignored
    set_req(0, 1'b0);
    set_req(2, 1'b0);
    step();
    mem_ready_i = 1'b0;
    set_req(0, 1'b1);
    s_ack_i = 1'b1;
    settle();
    check("t4_spurious_ack", 256'(m_ack_o), 256'(3'b000));
    s_ack_i = 1'b0;
    repeat (20) begin
      step();
      settle();
      check("t4_blocked_cyc",   256'(s_cyc_o), 256'(1'b0));
      check("t4_blocked_grant", 256'(grant_o), 256'(3'b000));
    end
    mem_ready_i = 1'b1;
    step();
    settle();
    check("t4_grant_after_ready", 256'(grant_o), 256'(3'b001));

    // Watchdog: slave never acks m0; m1 waits
    set_req(1, 1'b1);
    check("t5_stb_first", 256'(s_stb_o), 256'(1'b1));
    repeat (14) step();
    settle();
    check("t5_stb_15",  256'(s_stb_o), 256'(1'b1));
    check("t5_no_err",  256'(m_err_o), 256'(3'b000));
    step();
    settle();
    check("t5_err",       256'(m_err_o), 256'(3'b001));
    check("t5_abort_cyc", 256'(s_cyc_o), 256'(1'b0));
    check("t5_abort_stb", 256'(s_stb_o), 256'(1'b0));
    step();
    settle();
    check("t5_err_once", 256'(m_err_o), 256'(3'b000));
    check("t5_idle",     256'(grant_o), 256'(3'b000));
    step();
    settle();
    check("t5_next_m1", 256'(grant_o), 256'(3'b010));

    // Asynchronous reset mid-transfer
    check("t6_busy", 256'(s_cyc_o), 256'(1'b1));
    rst_n   = 1'b0;
    s_ack_i = 1'b1;
    settle();
    check("t6_grant", 256'(grant_o),  256'(3'b000));
    check("t6_s_cyc", 256'(s_cyc_o),  256'(1'b0));
    check("t6_s_stb", 256'(s_stb_o),  256'(1'b0));
    check("t6_s_adr", 256'(s_addr_o), 256'(32'h0));
    check("t6_ack",   256'(m_ack_o),  256'(3'b000));
    check("t6_err",   256'(m_err_o),  256'(3'b000));
    step();
    s_ack_i = 1'b0;
    rst_n   = 1'b1;
    step();
    settle();
    check("t6_m0_first", 256'(grant_o), 256'(3'b001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
